// File: rtl/instr_encoder.sv
// instr_encoder: streams instruction descriptors into MIPS-I machine words and
// writes them to consecutive instruction-memory addresses.
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   start, base_addr      : begin a load at base_addr (honoured in IDLE only)
//   in_valid/in_ready     : descriptor handshake
//   in_id, in_rs, in_rt,
//   in_rd, in_shamt,
//   in_imm, in_last       : descriptor fields; in_last ends the load
//   im_we/im_ready        : memory write handshake
//   im_addr, im_wdata     : write address and encoded word
//   busy, done            : load in progress / one-cycle completion pulse
//   err, err_id           : sticky illegal-ID flag and first illegal ID seen
//   ovf                   : sticky flag, a write landed on the last address
//   count                 : words written in the current (or last) load
module instr_encoder #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_id,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  input  logic              im_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf,
  output logic [5:0]        err_id,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic                im_we_q, im_we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;
  logic [5:0]          err_id_q, err_id_d;
  logic [ADDR_W:0]     count_q, count_d;

  // Encoder
  logic        enc_legal, enc_is_r, enc_is_j;
  logic [5:0]  enc_op, enc_funct;
  logic [4:0]  enc_rs, enc_rt, enc_rd, enc_shamt;
  logic [31:0] enc_word;

  always_comb begin
    enc_legal = 1'b1;
    enc_is_r  = 1'b0;
    enc_is_j  = 1'b0;
    enc_op    = 6'h00;
    enc_funct = 6'h00;
    case (in_id)
      6'd0:  begin enc_is_r = 1'b1; enc_funct = 6'h20; end // add
      6'd1:  begin enc_is_r = 1'b1; enc_funct = 6'h22; end // sub
      6'd2:  begin enc_is_r = 1'b1; enc_funct = 6'h24; end // and
      6'd3:  begin enc_is_r = 1'b1; enc_funct = 6'h25; end // or
      6'd4:  begin enc_is_r = 1'b1; enc_funct = 6'h2a; end // slt
      6'd5:  begin enc_is_r = 1'b1; enc_funct = 6'h2b; end // sltu
      6'd6:  begin enc_is_r = 1'b1; enc_funct = 6'h21; end // addu
      6'd7:  begin enc_is_r = 1'b1; enc_funct = 6'h23; end // subu
      6'd8:  begin enc_is_r = 1'b1; enc_funct = 6'h00; end // sll
      6'd9:  begin enc_is_r = 1'b1; enc_funct = 6'h02; end // srl
      6'd10: begin enc_is_r = 1'b1; enc_funct = 6'h04; end // sllv
      6'd11: begin enc_is_r = 1'b1; enc_funct = 6'h06; end // srlv
      6'd12: begin enc_is_r = 1'b1; enc_funct = 6'h27; end // nor
      6'd13: begin enc_is_r = 1'b1; enc_funct = 6'h08; end // jr
      6'd14: begin enc_is_r = 1'b1; enc_funct = 6'h09; end // jalr
      6'd15: begin enc_is_r = 1'b1; enc_funct = 6'h26; end // xor
      6'd16: begin enc_is_r = 1'b1; enc_funct = 6'h03; end // sra
      6'd17: begin enc_is_r = 1'b1; enc_funct = 6'h07; end // srav
      6'd18: enc_op = 6'h08; // addi
      6'd19: enc_op = 6'h0d; // ori
      6'd20: enc_op = 6'h23; // lw
      6'd21: enc_op = 6'h2b; // sw
      6'd22: enc_op = 6'h04; // beq
      6'd23: enc_op = 6'h05; // bne
      6'd24: enc_op = 6'h0a; // slti
      6'd25: enc_op = 6'h0f; // lui
      6'd26: enc_op = 6'h0c; // andi
      6'd27: enc_op = 6'h20; // lb
      6'd28: enc_op = 6'h21; // lh
      6'd29: enc_op = 6'h24; // lbu
      6'd30: enc_op = 6'h25; // lhu
      6'd31: enc_op = 6'h28; // sb
      6'd32: enc_op = 6'h29; // sh
      6'd33: begin enc_is_j = 1'b1; enc_op = 6'h02; end // j
      6'd34: begin enc_is_j = 1'b1; enc_op = 6'h03; end // jal
      default: enc_legal = 1'b0;
    endcase

    // Field forcing: only immediate shifts carry shamt, jr/jalr/lui zero unused regs.
    enc_shamt = (in_id == 6'd8 || in_id == 6'd9 || in_id == 6'd16) ? in_shamt : 5'd0;
    enc_rt    = (in_id == 6'd13 || in_id == 6'd14) ? 5'd0 : in_rt;
    enc_rd    = (in_id == 6'd13) ? 5'd0 : in_rd;
    enc_rs    = (in_id == 6'd25) ? 5'd0 : in_rs;

    if (enc_is_r) begin
      enc_word = {6'b000000, enc_rs, enc_rt, enc_rd, enc_shamt, enc_funct};
    end else if (enc_is_j) begin
      enc_word = {enc_op, in_imm};
    end else begin
      enc_word = {enc_op, enc_rs, enc_rt, in_imm[15:0]};
    end
  end

  // Control
  logic accept, wr_done;

  assign in_ready = (state_q == StRun) & (~im_we_q | im_ready);
  assign accept   = in_valid & in_ready;
  assign wr_done  = im_we_q & im_ready;

  always_comb begin
    state_d  = state_q;
    im_we_d  = im_we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    err_id_d = err_id_q;
    count_d  = count_q;

    if (wr_done) begin
      im_we_d = 1'b0;
      addr_d  = addr_q + ADDR_W'(1);
      count_d = count_q + (ADDR_W + 1)'(1);
      if (&addr_q) ovf_d = 1'b1;
    end

    // A new word can load in the same cycle the previous one retires.
    if (accept && enc_legal) begin
      im_we_d = 1'b1;
      wdata_d = enc_word;
    end

    if (accept && !enc_legal && !err_q) begin
      err_d    = 1'b1;
      err_id_d = in_id;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          addr_d   = base_addr;
          count_d  = '0;
          err_d    = 1'b0;
          ovf_d    = 1'b0;
          err_id_d = 6'd0;
        end
      end
      StRun:   if (accept && in_last) state_d = StDrain;
      StDrain: if (!im_we_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      im_we_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_id_q <= 6'd0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      im_we_q  <= im_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      err_id_q <= err_id_d;
      count_q  <= count_d;
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign busy     = (state_q == StRun) | (state_q == StDrain);
  assign done     = (state_q == StDone);
  assign err      = err_q;
  assign ovf      = ovf_q;
  assign err_id   = err_id_q;
  assign count    = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// loads, checked against a table-driven encoding model and an expected-write queue.
module tb_instr_encoder;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, in_last, im_we, im_ready;
  logic [AW-1:0] base_addr, im_addr;
  logic [5:0]    in_id, err_id;
  logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
  logic [25:0]   in_imm;
  logic [31:0]   im_wdata;
  logic          busy, done, err, ovf;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_last(in_last), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .im_ready(im_ready), .busy(busy), .done(done), .err(err), .ovf(ovf),
    .err_id(err_id), .count(count)
  );

  // Standard MIPS-I funct / opcode tables indexed by ID.
  localparam int unsigned R_FUNCT [18] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2a, 32'h2b,
    32'h21, 32'h23, 32'h00, 32'h02, 32'h04, 32'h06, 32'h27, 32'h08, 32'h09, 32'h26, 32'h03,
    32'h07};
  localparam int unsigned I_OP [15] = '{32'h08, 32'h0d, 32'h23, 32'h2b, 32'h04, 32'h05,
    32'h0a, 32'h0f, 32'h0c, 32'h20, 32'h21, 32'h24, 32'h25, 32'h28, 32'h29};
  localparam int unsigned J_OP [2] = '{32'h02, 32'h03};

  int tests = 0;
  int fails = 0;

  logic [AW+31:0] exp_q[$];
  logic [AW-1:0]  addr_m;
  int             legal_m;
  bit             err_m, ovf_m, acc;
  logic [5:0]     err_id_m;

  function automatic logic [31:0] ref_encode(input int unsigned id, input int unsigned rs,
                                             input int unsigned rt, input int unsigned rd,
                                             input int unsigned sh, input int unsigned imm);
    int unsigned w;
    if (id < 18) begin
      if (!(id == 8 || id == 9 || id == 16)) sh = 0;
      if (id == 13 || id == 14) rt = 0;
      if (id == 13) rd = 0;
      w = (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | R_FUNCT[id];
    end else if (id < 33) begin
      if (id == 25) rs = 0;
      w = (I_OP[id - 18] << 26) | (rs << 21) | (rt << 16) | (imm % 65536);
    end else begin
      w = (J_OP[id - 33] << 26) | (imm % 67108864);
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: handshakes are judged at the falling edge, outputs settle by posedge+1.
  task automatic cycle();
    @(negedge clk);
    acc = in_valid && in_ready;
    if (im_we === 1'b1 && im_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", {im_addr, im_wdata}, '0);
      else chk("write", {im_addr, im_wdata}, exp_q.pop_front());
    end
    if (acc) begin
      if (in_id < 6'd35) begin
        exp_q.push_back({addr_m, ref_encode(in_id, in_rs, in_rt, in_rd, in_shamt, in_imm)});
        if (addr_m == {AW{1'b1}}) ovf_m = 1'b1;
        addr_m++;
        legal_m++;
      end else if (!err_m) begin
        err_m    = 1'b1;
        err_id_m = in_id;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    start = 1'b1;
    base_addr = base;
    cycle();
    start = 1'b0;
    addr_m = base; legal_m = 0; err_m = 1'b0; ovf_m = 1'b0; err_id_m = 6'd0;
    exp_q.delete();
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic send(input int unsigned id, input int unsigned rs, input int unsigned rt,
                      input int unsigned rd, input int unsigned sh, input int unsigned imm,
                      input bit last, input bit rnd_ready);
    in_valid = 1'b1; in_id = 6'(id); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_shamt = 5'(sh); in_imm = 26'(imm); in_last = last;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      if (rnd_ready) im_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    chk("accepted", acc, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit rnd_ready);
    bit seen = 1'b0;
    logic [AW:0] cnt;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (rnd_ready) im_ready = ($urandom_range(0, 3) != 0);
        cycle();
      end
    end
    chk({tag, "_done"}, seen, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_count"}, count, (AW + 1)'(legal_m));
    chk({tag, "_err"}, err, err_m);
    chk({tag, "_err_id"}, err_id, err_id_m);
    chk({tag, "_ovf"}, ovf, ovf_m);
    chk({tag, "_pending"}, exp_q.size(), 0);
    cnt = count;
    im_ready = 1'b1;
    cycle();
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_count_hold"}, count, cnt);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_im_we"}, im_we, 1'b0);
    chk({tag, "_im_addr"}, im_addr, '0);
    chk({tag, "_im_wdata"}, im_wdata, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_ovf"}, ovf, 1'b0);
    chk({tag, "_err_id"}, err_id, '0);
    chk({tag, "_count"}, count, '0);
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_id = '0; in_rs = '0;
    in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_last = 1'b0; im_ready = 1'b1;
    addr_m = '0; legal_m = 0; err_m = 1'b0; ovf_m = 1'b0; err_id_m = '0; acc = 1'b0;
    #1;
    check_zero("reset");
    #12 rst = 1'b0;
    @(posedge clk); #1;

    // Directed single descriptors
    do_start(10'h010);
    send(0, 1, 2, 3, 0, 0, 1'b0, 1'b0);
    chk("add_word", {im_addr, im_wdata}, {10'h010, 32'h00221820});
    send(18, 1, 2, 0, 0, 5, 1'b0, 1'b0);
    chk("addi_word", {im_addr, im_wdata}, {10'h011, 32'h20220005});
    send(20, 29, 8, 0, 0, 4, 1'b0, 1'b0);
    chk("lw_word", {im_addr, im_wdata}, {10'h012, 32'h8FA80004});
    send(8, 0, 1, 2, 4, 0, 1'b0, 1'b0);
    chk("sll_word", {im_addr, im_wdata}, {10'h013, 32'h00011100});
    send(33, 0, 0, 0, 0, 32'h100, 1'b1, 1'b0);
    chk("j_word", {im_addr, im_wdata}, {10'h014, 32'h08000100});
    wait_done("basic", 1'b0);
    chk("basic_count5", count, 11'd5);

    // Backpressure: second descriptor waits while the first word is stalled
    do_start(10'h100);
    im_ready = 1'b0;
    send(3, 4, 5, 6, 7, 0, 1'b0, 1'b0);
    held = im_wdata;
    in_valid = 1'b1; in_id = 6'd19; in_rs = 5'd9; in_rt = 5'd10; in_imm = 26'h1234;
    in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 1'b0);
      cycle();
      chk("bp_im_we", im_we, 1'b1);
      chk("bp_wdata_held", im_wdata, held);
    end
    im_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) cycle();
    chk("bp_accepted", acc, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_done("bp", 1'b0);

    // Illegal ID in the middle
    do_start(10'h200);
    send(6, 1, 2, 3, 0, 0, 1'b0, 1'b0);
    send(40, 1, 2, 3, 0, 0, 1'b0, 1'b0);
    send(41, 1, 2, 3, 0, 0, 1'b0, 1'b0);
    send(34, 0, 0, 0, 0, 26'h3ABCDEF, 1'b1, 1'b0);
    wait_done("illegal", 1'b0);
    chk("illegal_err_id40", err_id, 6'd40);
    chk("illegal_count2", count, 11'd2);

    // Address wrap
    do_start(10'h3FF);
    send(25, 7, 8, 0, 0, 26'hBEEF, 1'b0, 1'b0);
    send(13, 31, 5, 6, 3, 0, 1'b1, 1'b0);
    wait_done("wrap", 1'b0);
    chk("wrap_ovf", ovf, 1'b1);

    // Reset during a stalled write
    do_start(10'h020);
    im_ready = 1'b0;
    send(50, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    send(1, 3, 4, 5, 0, 0, 1'b0, 1'b0);
    chk("rst_pre_we", im_we, 1'b1);
    chk("rst_pre_err", err, 1'b1);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    exp_q.delete();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    im_ready = 1'b1;
    do_start(10'h030);
    send(2, 1, 1, 1, 0, 0, 1'b0, 1'b0);
    send(21, 2, 3, 0, 0, 16, 1'b1, 1'b0);
    wait_done("after_rst", 1'b0);

    // start during RUN is ignored
    do_start(10'h040);
    send(15, 1, 2, 3, 0, 0, 1'b0, 1'b0);
    start = 1'b1; base_addr = 10'h200;
    cycle();
    start = 1'b0;
    chk("restart_busy", busy, 1'b1);
    send(17, 4, 5, 6, 9, 0, 1'b1, 1'b0);
    wait_done("restart", 1'b0);

    // Randomized loads with random memory backpressure
    for (int l = 0; l < 8; l++) begin
      int n;
      do_start(AW'($urandom_range(0, (1 << AW) - 1)));
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) begin
        int unsigned id;
        id = ($urandom_range(0, 4) == 0) ? $urandom_range(35, 63) : $urandom_range(0, 34);
        send(id, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom & 32'h03FFFFFF, k == n - 1, 1'b1);
      end
      wait_done("rand", 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, pulse that begins a program load.
REQ-005 SHALL have port base_addr, input, ADDR_W, first word address, sampled on start.
REQ-006 SHALL have port in_valid, input, 1, instruction descriptor valid.
REQ-007 SHALL have port in_ready, output, 1, descriptor accepted when in_valid and in_ready are both 1.
REQ-008 SHALL have port in_id, input, 6, instruction ID per REQ-014.
REQ-009 SHALL have port in_rs, in_rt, in_rd and in_shamt, input, 5 each, register and shift fields.
REQ-010 SHALL have port in_imm, input, 26, imm16 in [15:0] or jump target [25:0].
REQ-011 SHALL have port in_last, input, 1, marks the final descriptor of the load.
REQ-012 SHALL have port im_we, output, 1, write request to instruction memory; im_addr, output, ADDR_W; im_wdata, output, 32; im_ready, input, 1, memory accepts the write when im_we and im_ready are both 1.
REQ-013 SHALL have ports busy, done, err and ovf, output, 1 each; err_id, output, 6; count, output, ADDR_W+1, number of words written.

Function
REQ-014 IDs: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sltu, 6 addu, 7 subu, 8 sll, 9 srl, 10 sllv, 11 srlv, 12 nor, 13 jr, 14 jalr, 15 xor, 16 sra, 17 srav, 18 addi, 19 ori, 20 lw, 21 sw, 22 beq, 23 bne, 24 slti, 25 lui, 26 andi, 27 lb, 28 lh, 29 lbu, 30 lhu, 31 sb, 32 sh, 33 j, 34 jal; IDs 35-63 are illegal.
REQ-015 All opcode and funct values SHALL be standard MIPS-I.
REQ-016 R-type IDs 0-17 SHALL encode as {6'b0, rs, rt, rd, shamt, funct}.
- shamt is forced to 0 except for sll, srl and sra.
- jr forces rt=rd=0; jalr forces rt=0.
REQ-017 I-type IDs 18-32 SHALL encode as {op, rs, rt, imm[15:0]}; lui forces rs=0.
REQ-018 J-type IDs 33-34 SHALL encode as {op, imm[25:0]}.
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
- IDLE -> RUN on start; addr counter := base_addr, count := 0.
- RUN -> DRAIN when a descriptor with in_last=1 is accepted.
- DRAIN -> DONE when the output stage is empty.
- DONE -> IDLE after one cycle.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 Output stage SHALL be a one-entry register.
- in_ready = (state==RUN) & (~im_we | im_ready).
- A descriptor accepted in cycle N presents im_we=1 with its word in cycle N+1.
- Throughput is one word per cycle while im_ready=1.
REQ-022 While im_we=1 and im_ready=0, im_we, im_addr and im_wdata SHALL hold stable.
REQ-023 On each completed write, the addr counter SHALL increment by 1, wrapping from 2^ADDR_W-1 to 0, and count SHALL increment by 1.
REQ-024 A write at address 2^ADDR_W-1 SHALL set sticky ovf.
REQ-025 An accepted illegal ID SHALL produce no write and no address or count change.
- Sets sticky err; err_id captures the first illegal ID only.
- If in_last=1 on that descriptor, RUN -> DRAIN still occurs.
REQ-026 busy SHALL be 1 in RUN and DRAIN; done SHALL be 1 only in DONE.
REQ-027 err, ovf and err_id SHALL clear on the start that leaves IDLE; count holds its value after DONE until the next start.

Reset
REQ-028 rst SHALL asynchronously force state=IDLE and clear all of the following: in_ready, im_we, im_addr, im_wdata, busy, done, err, ovf, err_id, count.
REQ-029 rst asserted mid-load SHALL abort the load, discarding any pending output word with no write.

Verification
REQ-030 Single descriptors, base_addr=0x010, im_ready=1:
- add rs=1 rt=2 rd=3 -> 0x00221820 @0x010.
- addi rs=1 rt=2 imm=5 -> 0x20220005 @0x011.
- lw rs=29 rt=8 imm=4 -> 0x8FA80004 @0x012.
- sll rt=1 rd=2 shamt=4 -> 0x00011100 @0x013.
- j imm=0x100 with in_last -> 0x08000100 @0x014, then done pulse, count=5.
REQ-031 Backpressure: im_ready=0 for 3 cycles with 2 descriptors queued -> in_ready=0, im_wdata held; both words are then written in order with no loss.
REQ-032 Illegal in_id=40 between two legal descriptors -> err=1, err_id=40, count=2, addresses contiguous.
REQ-033 Wrap: base_addr=0x3FF with 2 descriptors -> writes at 0x3FF then 0x000, ovf=1.
REQ-034 rst asserted while im_we=1 and im_ready=0 -> all outputs 0 immediately; a following start begins a clean load.
REQ-035 start asserted during RUN -> ignored; base_addr is not resampled.
